hsv2rgb: RTL
============

// Module: hsv2rgb
// PURPOSE
//  Converts 8-bit HSV pixels back to 8-bit RGB in a fixed-latency pipeline.
//  Hue uses the 0..255 circle: red=0, green=85, blue=170. Sits after the
//  colour-threshold/tint stage, which works in HSV, and feeds the RGB
//  display/ZBT writer path.
//  A sideband (syncs) travels alongside so video timing stays aligned.
// PARAMETERS
//  SYNC_W   2   width of the sideband bus delayed with each pixel
// PORTS
//  clock      in   1       system clock; all logic on posedge
//  reset      in   1       asynchronous, active-low; clears all state
//  ce         in   1       pipeline enable; 0 freezes every pipeline register
//  in_valid   in   1       h/s/v/in_sync valid this cycle; sampled only when ce=1
//  h          in   8       hue, 0..255 circle
//  s          in   8       saturation, 0..255
//  v          in   8       value, 0..255
//  in_sync    in   SYNC_W  sideband, passed through unchanged
//  out_valid  out  1       r/g/b/out_sync valid
//  r, g, b    out  8 each  RGB result
//  out_sync   out  SYNC_W  sideband delayed by exactly LATENCY
// BEHAVIOUR
//  - Reset (reset=0, async): all pipeline registers and outputs go to 0,
//    including out_valid. In-flight pixels are discarded.
//  - No pixel emerges until LATENCY=5 enabled cycles after release.
//  - Latency: 5 enabled clock edges from input sample to registered output.
//    Fully pipelined, 1 pixel/clock when ce=1; no back-pressure.
//    Valid, sync and data shift together.
//  - ce=0: all stage registers hold, including valid/sync and outputs.
//    Inputs are ignored that cycle. ce deasserted mid-stream loses no data.
//  - in_valid=0 pixels flow as bubbles. out_valid=0 for them.
//    Data outputs are don't-care then, but must still be deterministic.
//  - Arithmetic (all unsigned, truncating >>8; results are bit-exact
//    requirements):
//     S1: latch h,s,v,valid,sync; h6 = h*6 (11b)
//     S2: region = h6[10:8] (0..5); f = h6[7:0];
//         sf = s*f; snf = s*(255-f) (16b); gray = (s==0)
//     S3: pp = v*(255-s); qa = 255-sf[15:8]; ta = 255-snf[15:8]
//     S4: p = pp[15:8]; q = (v*qa)>>8; t = (v*ta)>>8
//     S5: registered select by region (r,g,b):
//         0:(v,t,p) 1:(q,v,p) 2:(p,v,t) 3:(p,q,v) 4:(t,p,v) 5:(v,p,q)
//  - Gray bypass: if gray, r=g=b=v exactly. Do not use p, which would give v-1.
//  - v=0 gives r=g=b=0 for any h or s.
//  - Region is never 6, since h6 max is 1530 = 0x5FA. No default arm is
//    reachable; code it as region 5.
//  - Hue wrap: h=255 lands in region 5 with f=250 (near red). No special case.
//  - The 16b products must not overflow: 255*255=65025 < 65536.
// TESTING
//  1. h=0,s=255,v=255 -> (255,0,0) after exactly 5 clocks with out_valid=1.
//  2. h=85,s=255,v=255 -> (1,255,0).
//     h=170,s=255,v=255 -> (0,3,255).
//     h=43,s=255,v=255 -> (253,255,0).
//  3. s=0,v=128, any h -> (128,128,128).
//     v=0,s=200,h=100 -> (0,0,0).
//  4. Back-to-back stream of 64 random pixels with sync tags: outputs match
//     the C model above in order; out_sync matches in_sync of the same pixel.
//  5. Drop ce for 3 cycles mid-stream, with in_valid toggling: no pixel is
//     lost, duplicated or reordered; outputs are held while ce=0.
//  6. Assert reset with 3 pixels in flight: out_valid=0 and r=g=b=0
//     immediately; none of those pixels appear after release.

Source files
------------

// File: rtl/hsv2rgb.sv
// Five-stage HSV -> RGB converter on the 0..255 hue circle (red=0, green=85, blue=170).
// A sideband sync bus and the valid flag travel with every pixel; ce freezes the whole pipe.
module hsv2rgb #(
    parameter int SYNC_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [7:0]        h,
    input  logic [7:0]        s,
    input  logic [7:0]        v,
    input  logic [SYNC_W-1:0] in_sync,
    output logic              out_valid,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic [SYNC_W-1:0] out_sync
);

    function automatic logic [15:0] mul8x8(input logic [7:0] a, input logic [7:0] c);
        return {8'd0, a} * {8'd0, c};
    endfunction

    function automatic logic [7:0] scale8(input logic [7:0] a, input logic [7:0] c);
        logic [15:0] prod;
        prod = mul8x8(a, c);
        return prod[15:8];
    endfunction

    // stage 1 state
    logic              vld_p1_q, vld_p1_d;
    logic [SYNC_W-1:0] sync_p1_q, sync_p1_d;
    logic [10:0]       h6_p1_q, h6_p1_d;
    logic [7:0]        s_p1_q, s_p1_d;
    logic [7:0]        v_p1_q, v_p1_d;

    // stage 2 state
    logic              vld_p2_q, vld_p2_d;
    logic [SYNC_W-1:0] sync_p2_q, sync_p2_d;
    logic [2:0]        region_p2_q, region_p2_d;
    logic [15:0]       sf_p2_q, sf_p2_d;
    logic [15:0]       snf_p2_q, snf_p2_d;
    logic              gray_p2_q, gray_p2_d;
    logic [7:0]        s_p2_q, s_p2_d;
    logic [7:0]        v_p2_q, v_p2_d;

    // stage 3 state
    logic              vld_p3_q, vld_p3_d;
    logic [SYNC_W-1:0] sync_p3_q, sync_p3_d;
    logic [2:0]        region_p3_q, region_p3_d;
    logic              gray_p3_q, gray_p3_d;
    logic [7:0]        v_p3_q, v_p3_d;
    logic [15:0]       pp_p3_q, pp_p3_d;
    logic [7:0]        qa_p3_q, qa_p3_d;
    logic [7:0]        ta_p3_q, ta_p3_d;

    // stage 4 state
    logic              vld_p4_q, vld_p4_d;
    logic [SYNC_W-1:0] sync_p4_q, sync_p4_d;
    logic [2:0]        region_p4_q, region_p4_d;
    logic              gray_p4_q, gray_p4_d;
    logic [7:0]        v_p4_q, v_p4_d;
    logic [7:0]        p_p4_q, p_p4_d;
    logic [7:0]        q_p4_q, q_p4_d;
    logic [7:0]        t_p4_q, t_p4_d;

    // stage 5 (output) state
    logic              vld_p5_q, vld_p5_d;
    logic [SYNC_W-1:0] sync_p5_q, sync_p5_d;
    logic [7:0]        r_p5_q, r_p5_d;
    logic [7:0]        g_p5_q, g_p5_d;
    logic [7:0]        b_p5_q, b_p5_d;

    always_comb begin
        // stage 1: latch inputs, scale hue to six sectors
        vld_p1_d  = in_valid;
        sync_p1_d = in_sync;
        h6_p1_d   = {3'd0, h} * 11'd6;
        s_p1_d    = s;
        v_p1_d    = v;

        // stage 2: sector and fractional position within it
        vld_p2_d    = vld_p1_q;
        sync_p2_d   = sync_p1_q;
        region_p2_d = h6_p1_q[10:8];
        sf_p2_d     = mul8x8(s_p1_q, h6_p1_q[7:0]);
        snf_p2_d    = mul8x8(s_p1_q, 8'd255 - h6_p1_q[7:0]);
        gray_p2_d   = (s_p1_q == 8'd0);
        s_p2_d      = s_p1_q;
        v_p2_d      = v_p1_q;

        // stage 3: attenuation factors
        vld_p3_d    = vld_p2_q;
        sync_p3_d   = sync_p2_q;
        region_p3_d = region_p2_q;
        gray_p3_d   = gray_p2_q;
        v_p3_d      = v_p2_q;
        pp_p3_d     = mul8x8(v_p2_q, 8'd255 - s_p2_q);
        qa_p3_d     = 8'd255 - sf_p2_q[15:8];
        ta_p3_d     = 8'd255 - snf_p2_q[15:8];

        // stage 4: scale by value
        vld_p4_d    = vld_p3_q;
        sync_p4_d   = sync_p3_q;
        region_p4_d = region_p3_q;
        gray_p4_d   = gray_p3_q;
        v_p4_d      = v_p3_q;
        p_p4_d      = pp_p3_q[15:8];
        q_p4_d      = scale8(v_p3_q, qa_p3_q);
        t_p4_d      = scale8(v_p3_q, ta_p3_q);

        // stage 5: sector select; region 6 cannot occur so it shares sector 5
        vld_p5_d  = vld_p4_q;
        sync_p5_d = sync_p4_q;
        case (region_p4_q)
            3'd0:    begin r_p5_d = v_p4_q; g_p5_d = t_p4_q; b_p5_d = p_p4_q; end
            3'd1:    begin r_p5_d = q_p4_q; g_p5_d = v_p4_q; b_p5_d = p_p4_q; end
            3'd2:    begin r_p5_d = p_p4_q; g_p5_d = v_p4_q; b_p5_d = t_p4_q; end
            3'd3:    begin r_p5_d = p_p4_q; g_p5_d = q_p4_q; b_p5_d = v_p4_q; end
            3'd4:    begin r_p5_d = t_p4_q; g_p5_d = p_p4_q; b_p5_d = v_p4_q; end
            default: begin r_p5_d = v_p4_q; g_p5_d = p_p4_q; b_p5_d = q_p4_q; end
        endcase
        // p truncates to v-1 at s=0, so gray takes v directly
        if (gray_p4_q) begin
            r_p5_d = v_p4_q;
            g_p5_d = v_p4_q;
            b_p5_d = v_p4_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1_q    <= 1'b0;
            sync_p1_q   <= '0;
            h6_p1_q     <= '0;
            s_p1_q      <= '0;
            v_p1_q      <= '0;
            vld_p2_q    <= 1'b0;
            sync_p2_q   <= '0;
            region_p2_q <= '0;
            sf_p2_q     <= '0;
            snf_p2_q    <= '0;
            gray_p2_q   <= 1'b0;
            s_p2_q      <= '0;
            v_p2_q      <= '0;
            vld_p3_q    <= 1'b0;
            sync_p3_q   <= '0;
            region_p3_q <= '0;
            gray_p3_q   <= 1'b0;
            v_p3_q      <= '0;
            pp_p3_q     <= '0;
            qa_p3_q     <= '0;
            ta_p3_q     <= '0;
            vld_p4_q    <= 1'b0;
            sync_p4_q   <= '0;
            region_p4_q <= '0;
            gray_p4_q   <= 1'b0;
            v_p4_q      <= '0;
            p_p4_q      <= '0;
            q_p4_q      <= '0;
            t_p4_q      <= '0;
            vld_p5_q    <= 1'b0;
            sync_p5_q   <= '0;
            r_p5_q      <= '0;
            g_p5_q      <= '0;
            b_p5_q      <= '0;
        end else if (ce) begin
            vld_p1_q    <= vld_p1_d;
            sync_p1_q   <= sync_p1_d;
            h6_p1_q     <= h6_p1_d;
            s_p1_q      <= s_p1_d;
            v_p1_q      <= v_p1_d;
            vld_p2_q    <= vld_p2_d;
            sync_p2_q   <= sync_p2_d;
            region_p2_q <= region_p2_d;
            sf_p2_q     <= sf_p2_d;
            snf_p2_q    <= snf_p2_d;
            gray_p2_q   <= gray_p2_d;
            s_p2_q      <= s_p2_d;
            v_p2_q      <= v_p2_d;
            vld_p3_q    <= vld_p3_d;
            sync_p3_q   <= sync_p3_d;
            region_p3_q <= region_p3_d;
            gray_p3_q   <= gray_p3_d;
            v_p3_q      <= v_p3_d;
            pp_p3_q     <= pp_p3_d;
            qa_p3_q     <= qa_p3_d;
            ta_p3_q     <= ta_p3_d;
            vld_p4_q    <= vld_p4_d;
            sync_p4_q   <= sync_p4_d;
            region_p4_q <= region_p4_d;
            gray_p4_q   <= gray_p4_d;
            v_p4_q      <= v_p4_d;
            p_p4_q      <= p_p4_d;
            q_p4_q      <= q_p4_d;
            t_p4_q      <= t_p4_d;
            vld_p5_q    <= vld_p5_d;
            sync_p5_q   <= sync_p5_d;
            r_p5_q      <= r_p5_d;
            g_p5_q      <= g_p5_d;
            b_p5_q      <= b_p5_d;
        end
    end

    assign out_valid = vld_p5_q;
    assign out_sync  = sync_p5_q;
    assign r         = r_p5_q;
    assign g         = g_p5_q;
    assign b         = b_p5_q;

endmodule
